// File: rtl/booth_mult_ctrl_8.sv
// 12x12 signed multiplier sequencer around the booth_8 radix-4 step unit.
// Digits are fed MSB-first, Horner style, over six cycles: acc = (acc<<2) + d*B.

module booth_8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [2:0]  mult_1,
    input  logic [11:0] mult_2,
    input  logic [23:0] mult_pre,
    output logic [23:0] mult_next
);

    // Partial product d*sext(m) for one Booth window; d in {-2,-1,0,+1,+2}
    function automatic logic [23:0] booth_pp(input logic [2:0] win, input logic [11:0] m);
        logic [23:0] m_ext;
        m_ext = {{12{m[11]}}, m};
        case (win)
            3'b000, 3'b111: booth_pp = 24'd0;
            3'b001, 3'b010: booth_pp = m_ext;
            3'b011:         booth_pp = m_ext << 1;
            3'b100:         booth_pp = 24'd0 - (m_ext << 1);
            3'b101, 3'b110: booth_pp = 24'd0 - m_ext;
            default:        booth_pp = 24'd0;
        endcase
    endfunction

    // Step register: accumulate while enabled, clear otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_next <= 24'd0;
        end else if (en) begin
            mult_next <= mult_pre + booth_pp(mult_1, mult_2);
        end else begin
            mult_next <= 24'd0;
        end
    end

endmodule

module booth_mult_ctrl_8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic        busy,
    output logic        done,
    output logic [23:0] product
);

    localparam int OP_W   = 12;
    localparam int PROD_W = 2 * OP_W;
    localparam int N_DIG  = OP_W / 2;
    localparam logic [2:0] TOP_DIG = 3'(N_DIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    state_t              state_r, state_s;
    logic [2:0]          cnt_r, cnt_s;
    logic [OP_W-1:0]     a_r, a_s;
    logic [OP_W-1:0]     b_r, b_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic [PROD_W-1:0]   product_r, product_s;

    logic                en_s;
    logic [2:0]          mult_1_s;
    logic [PROD_W-1:0]   mult_pre_s;
    logic [PROD_W-1:0]   mult_next_s;

    // Booth window {a[2i+1], a[2i], a[2i-1]} with a[-1] = 0
    function automatic logic [2:0] booth_window(input logic [11:0] op, input logic [2:0] idx);
        case (idx)
            3'd0:    booth_window = {op[1:0], 1'b0};
            3'd1:    booth_window = op[3:1];
            3'd2:    booth_window = op[5:3];
            3'd3:    booth_window = op[7:5];
            3'd4:    booth_window = op[9:7];
            3'd5:    booth_window = op[11:9];
            default: booth_window = 3'b000;
        endcase
    endfunction

    booth_8 u_step (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en_s),
        .mult_1    (mult_1_s),
        .mult_2    (b_r),
        .mult_pre  (mult_pre_s),
        .mult_next (mult_next_s)
    );

    // Next-state and datapath control
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        a_s        = a_r;
        b_s        = b_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        product_s  = product_r;
        en_s       = 1'b0;
        mult_1_s   = 3'b000;
        mult_pre_s = 24'd0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    a_s     = a;
                    b_s     = b;
                    cnt_s   = TOP_DIG;
                    busy_s  = 1'b1;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                en_s     = 1'b1;
                mult_1_s = booth_window(a_r, cnt_r);
                // The first (most significant) digit starts from a clean accumulator
                if (cnt_r == TOP_DIG) begin
                    mult_pre_s = 24'd0;
                end else begin
                    mult_pre_s = {mult_next_s[PROD_W-3:0], 2'b00};
                end
                if (cnt_r == 3'd0) begin
                    state_s = FIN;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            FIN: begin
                product_s = mult_next_s;
                done_s    = 1'b1;
                busy_s    = 1'b0;
                state_s   = IDLE;
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= 3'd0;
            a_r       <= 12'd0;
            b_r       <= 12'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= 24'd0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            a_r       <= a_s;
            b_r       <= b_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            product_r <= product_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_booth_mult_ctrl_8.sv
// Scoreboard bench for booth_mult_ctrl_8: stimulus pushes expected products,
// a negedge monitor pops and compares on every done pulse.

module tb_booth_mult_ctrl_8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] a;
    logic [11:0] b;
    logic        busy;
    logic        done;
    logic [23:0] product;

    int          checks;
    int          errors;
    int          done_cnt;
    logic [23:0] exp_q[$];
    logic [23:0] last_prod;

    logic [11:0] a_tab [10];
    logic [11:0] b_tab [10];
    logic [23:0] p_tab [10];

    booth_mult_ctrl_8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got product %h expected no done", product);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if (product !== e) begin
                    errors++;
                    $display("FAIL product: got %h expected %h", product, e);
                end
            end
        end
    end

    // Issue one op at a negedge; returns at the first negedge after the accepting edge
    task automatic issue(input logic [11:0] av, input logic [11:0] bv, input logic [23:0] pv);
        a     = av;
        b     = bv;
        start = 1'b1;
        exp_q.push_back(pv);
        @(negedge clk);
        start = 1'b0;
        a     = 12'h000;
        b     = 12'h000;
    endtask

    // Wait for done, measuring latency and busy width; optional start re-pulse in RUN
    task automatic wait_done(input string name, input bit repulse, output int k);
        int busy_cnt;
        busy_cnt = 0;
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            if (busy === 1'b1) busy_cnt++;
            if (k == 3) check({name, "_product_hold"}, {8'h00, product}, {8'h00, last_prod});
            if (repulse && k == 2) begin
                start = 1'b1; a = 12'h001; b = 12'h001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check({name, "_latency"}, 32'(k), 32'd7);
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd7);
        check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int k;
        int dc;
        checks = 0; errors = 0; done_cnt = 0;
        start = 1'b0; a = 12'h000; b = 12'h000;
        last_prod = 24'h000000;

        a_tab = '{12'h003, 12'h800, 12'h7FF, 12'h000, 12'h7FF,
                  12'h801, 12'hFFF, 12'h800, 12'h001, 12'hFFB};
        b_tab = '{12'h005, 12'h800, 12'h800, 12'hFFF, 12'h7FF,
                  12'h7FF, 12'hFFF, 12'h7FF, 12'h800, 12'hFFD};
        p_tab = '{24'h00000F, 24'h400000, 24'hC00800, 24'h000000, 24'h3FF001,
                  24'hC00FFF, 24'h000001, 24'hC00800, 24'hFFF800, 24'h00000F};

        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check("reset_busy",    {31'd0, busy},    32'd0);
        check("reset_done",    {31'd0, done},    32'd0);
        check("reset_product", {8'h00, product}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            issue(a_tab[i], b_tab[i], p_tab[i]);
            wait_done($sformatf("vec%0d", i), 1'b0, k);
            last_prod = p_tab[i];
            @(negedge clk);
        end

        // Re-pulsed start during RUN must be ignored: exactly one done
        dc = done_cnt;
        issue(12'hFF9, 12'h009, 24'hFFFFC1);
        wait_done("repulse", 1'b1, k);
        last_prod = 24'hFFFFC1;
        repeat (12) @(negedge clk);
        check("repulse_done_count", 32'(done_cnt - dc), 32'd1);

        // Back-to-back: second start issued in the done cycle
        issue(12'h003, 12'h005, 24'h00000F);
        wait_done("b2b_first", 1'b0, k);
        last_prod = 24'h00000F;
        issue(12'hFF9, 12'h009, 24'hFFFFC1);
        k = 1;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("b2b_spacing", 32'(k), 32'd8);
        last_prod = 24'hFFFFC1;
        @(negedge clk);

        // Reset in the third RUN cycle aborts the op with no done pulse
        dc = done_cnt;
        a = 12'h005; b = 12'h005; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy",    {31'd0, busy},    32'd0);
        check("abort_done",    {31'd0, done},    32'd0);
        check("abort_product", {8'h00, product}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - dc), 32'd0);
        last_prod = 24'h000000;

        issue(12'h800, 12'h800, 24'h400000);
        wait_done("after_abort", 1'b0, k);
        repeat (3) @(negedge clk);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
